// File: rtl/timer_tick_master_if.sv
// Avalon-MM bus between the tick master and the interval timer.
// master: address/chipselect/write_n/writedata out, readdata/irq in.
interface timer_tick_master_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/timer_tick_master.sv
// Programs the interval timer, services its irq and keeps hh:mm:ss.
// Ports: clk, reset_n, enable, set_*, bus (timer), time of day, flags.
module timer_tick_master #(
  parameter int PERIOD        = 49999,
  parameter int TICKS_PER_SEC = 1000,
  parameter int MAX_RETRY     = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        set_valid,
  input  logic [4:0]  set_hours,
  input  logic [5:0]  set_minutes,
  input  logic [5:0]  set_seconds,
  timer_tick_master_if.master bus,
  output logic [4:0]  hours,
  output logic [5:0]  minutes,
  output logic [5:0]  seconds,
  output logic        sec_pulse,
  output logic        running,
  output logic        error
);

  localparam logic [31:0] PER = 32'(PERIOD);
  localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_SEC - 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL, RD_STAT,
    RD_WAIT, WAIT_IRQ, CLR_STAT, WR_STOP
  } state_t;

  state_t state_q, state_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] tick_q;
  logic error_d, enable_q, tick_en;
  logic cs_d, wn_d;
  logic [2:0] addr_d;
  logic [15:0] wd_d;
  logic unused_rd;

  assign unused_rd = ^{bus.readdata[15:2], bus.readdata[0]};
  assign running = (state_q == WAIT_IRQ) || (state_q == CLR_STAT);

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    error_d = error;
    tick_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        // a falling enable while parked is the only soft way out of error
        if (enable_q && !enable) error_d = 1'b0;
        if (enable && !error) state_d = WR_PL;
      end
      WR_PL:   state_d = WR_PH;
      WR_PH:   state_d = WR_CTRL;
      WR_CTRL: state_d = RD_STAT;
      RD_STAT: state_d = RD_WAIT;
      RD_WAIT: begin
        if (bus.readdata[1]) begin
          state_d = WAIT_IRQ;
          retry_d = '0;
        end else if (retry_q == RETRY_LAST) begin
          state_d = IDLE;
          retry_d = '0;
          error_d = 1'b1;
        end else begin
          state_d = WR_PL;
          retry_d = retry_q + 1'b1;
        end
      end
      WAIT_IRQ: begin
        if (!enable) state_d = WR_STOP;
        else if (bus.irq) state_d = CLR_STAT;
      end
      CLR_STAT: begin
        tick_en = 1'b1;
        state_d = WAIT_IRQ;
      end
      WR_STOP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // bus outputs follow the state being entered so they are registered
  always_comb begin
    cs_d   = 1'b0;
    wn_d   = 1'b1;
    addr_d = 3'd0;
    wd_d   = 16'd0;
    unique case (state_d)
      WR_PL: begin
        cs_d = 1'b1; wn_d = 1'b0;
        addr_d = 3'd2; wd_d = PER[15:0];
      end
      WR_PH: begin
        cs_d = 1'b1; wn_d = 1'b0;
        addr_d = 3'd3; wd_d = PER[31:16];
      end
      WR_CTRL: begin
        cs_d = 1'b1; wn_d = 1'b0;
        addr_d = 3'd1; wd_d = 16'h0007;
      end
      RD_STAT: cs_d = 1'b1;
      CLR_STAT: begin
        cs_d = 1'b1; wn_d = 1'b0;
      end
      WR_STOP: begin
        cs_d = 1'b1; wn_d = 1'b0;
        addr_d = 3'd1; wd_d = 16'h0008;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      retry_q        <= '0;
      error          <= 1'b0;
      enable_q       <= 1'b0;
      bus.chipselect <= 1'b0;
      bus.write_n    <= 1'b1;
      bus.address    <= 3'd0;
      bus.writedata  <= 16'd0;
    end else begin
      state_q        <= state_d;
      retry_q        <= retry_d;
      error          <= error_d;
      enable_q       <= enable;
      bus.chipselect <= cs_d;
      bus.write_n    <= wn_d;
      bus.address    <= addr_d;
      bus.writedata  <= wd_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q    <= '0;
      hours     <= 5'd0;
      minutes   <= 6'd0;
      seconds   <= 6'd0;
      sec_pulse <= 1'b0;
    end else begin
      sec_pulse <= 1'b0;
      if (set_valid) begin
        tick_q  <= '0;
        hours   <= (set_hours > 5'd23) ? 5'd23 : set_hours;
        minutes <= (set_minutes > 6'd59) ? 6'd59 : set_minutes;
        seconds <= (set_seconds > 6'd59) ? 6'd59 : set_seconds;
      end else if (tick_en) begin
        if (tick_q == TICK_MAX) begin
          tick_q    <= '0;
          sec_pulse <= 1'b1;
          if (seconds == 6'd59) begin
            seconds <= 6'd0;
            if (minutes == 6'd59) begin
              minutes <= 6'd0;
              hours   <= (hours == 5'd23) ? 5'd0 : hours + 1'b1;
            end else begin
              minutes <= minutes + 1'b1;
            end
          end else begin
            seconds <= seconds + 1'b1;
          end
        end else begin
          tick_q <= tick_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_tick_master.sv
// Directed bench for timer_tick_master with a small interval-timer model.
// Instance a: default period; instance b: PERIOD=9, TICKS_PER_SEC=4.
module tb_timer_tick_master;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  timer_tick_master_if bus_a ();
  timer_tick_master_if bus_b ();

  logic en_a = 1'b0;
  logic en_b = 1'b0;
  logic sv_b = 1'b0;
  logic [4:0] sh_b = 5'd0;
  logic [5:0] sm_b = 6'd0;
  logic [5:0] ss_b = 6'd0;
  logic [4:0] h_a, h_b;
  logic [5:0] m_a, s_a, m_b, s_b;
  logic p_a, p_b, run_a, run_b, err_a, err_b;

  timer_tick_master u_a (
    .clk(clk), .reset_n(reset_n), .enable(en_a),
    .set_valid(1'b0), .set_hours(5'd0),
    .set_minutes(6'd0), .set_seconds(6'd0),
    .bus(bus_a.master),
    .hours(h_a), .minutes(m_a), .seconds(s_a),
    .sec_pulse(p_a), .running(run_a), .error(err_a)
  );

  timer_tick_master #(.PERIOD(9), .TICKS_PER_SEC(4)) u_b (
    .clk(clk), .reset_n(reset_n), .enable(en_b),
    .set_valid(sv_b), .set_hours(sh_b),
    .set_minutes(sm_b), .set_seconds(ss_b),
    .bus(bus_b.master),
    .hours(h_b), .minutes(m_b), .seconds(s_b),
    .sec_pulse(p_b), .running(run_b), .error(err_b)
  );

  assign bus_a.readdata = 16'h0002;
  assign bus_a.irq = 1'b0;

  // interval timer model for instance b
  bit norun = 1'b0;
  logic [15:0] m_pl, m_ph;
  logic [31:0] m_cnt;
  logic m_run, m_to, m_ito;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pl <= 16'd0; m_ph <= 16'd0; m_cnt <= 32'd0;
      m_run <= 1'b0; m_to <= 1'b0; m_ito <= 1'b0;
      bus_b.readdata <= 16'd0;
    end else begin
      if (m_run) begin
        if (m_cnt == 32'd0) begin
          m_to <= 1'b1;
          m_cnt <= {m_ph, m_pl};
        end else begin
          m_cnt <= m_cnt - 32'd1;
        end
      end
      if (bus_b.chipselect && !bus_b.write_n) begin
        case (bus_b.address)
          3'd0: m_to <= 1'b0;
          3'd1: begin
            m_ito <= bus_b.writedata[0];
            if (bus_b.writedata[2]) begin
              m_run <= 1'b1;
              m_cnt <= {m_ph, m_pl};
            end
            if (bus_b.writedata[3]) m_run <= 1'b0;
          end
          3'd2: m_pl <= bus_b.writedata;
          3'd3: m_ph <= bus_b.writedata;
          default: ;
        endcase
      end
      if (bus_b.chipselect && bus_b.write_n)
        bus_b.readdata <= {14'd0, m_run & ~norun, m_to};
    end
  end

  assign bus_b.irq = m_to & m_ito;

  int n_clr = 0;
  int n_start = 0;
  int n_cs = 0;

  always @(posedge clk) begin
    if (bus_b.chipselect && !bus_b.write_n && bus_b.address == 3'd0)
      n_clr <= n_clr + 1;
    if (bus_b.chipselect && !bus_b.write_n &&
        bus_b.address == 3'd1 && bus_b.writedata == 16'h0007)
      n_start <= n_start + 1;
    if (bus_b.chipselect) n_cs <= n_cs + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bw(input logic cs, input logic wn,
                                     input logic [2:0] a,
                                     input logic [15:0] d);
    return {11'd0, cs, wn, a, d};
  endfunction

  function automatic logic [31:0] tod(input logic [4:0] h,
                                      input logic [5:0] m,
                                      input logic [5:0] s);
    return {15'd0, h, m, s};
  endfunction

  task automatic wait_run(input int lim);
    int k = 0;
    while (!run_b && k < lim) begin
      @(negedge clk);
      k++;
    end
    if (!run_b) check("run_timeout", run_b, 1);
  endtask

  task automatic wait_pulse(input int lim, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!p_b && waited < lim);
    if (!p_b) check("pulse_timeout", p_b, 1);
  endtask

  task automatic wait_clr(input int n, input int lim);
    int seen = 0;
    int k = 0;
    while (seen < n && k < lim) begin
      @(negedge clk);
      k++;
      if (bus_b.chipselect && !bus_b.write_n && bus_b.address == 3'd0)
        seen++;
    end
    if (seen < n) check("clr_timeout", seen, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, s1, k1, cnt, first, snap_s, snap_c;

    repeat (3) @(negedge clk);
    check("rst_bus_b", bw(bus_b.chipselect, bus_b.write_n,
          bus_b.address, bus_b.writedata), bw(0, 1, 0, 0));
    check("rst_tod_b", tod(h_b, m_b, s_b), 0);
    check("rst_flags_b", {p_b, run_b, err_b}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // default-period programming sequence
    en_a = 1'b1;
    @(negedge clk);
    check("a_wr_pl", bw(bus_a.chipselect, bus_a.write_n,
          bus_a.address, bus_a.writedata), bw(1, 0, 2, 16'hC34F));
    @(negedge clk);
    check("a_wr_ph", bw(bus_a.chipselect, bus_a.write_n,
          bus_a.address, bus_a.writedata), bw(1, 0, 3, 16'h0000));
    @(negedge clk);
    check("a_wr_ctrl", bw(bus_a.chipselect, bus_a.write_n,
          bus_a.address, bus_a.writedata), bw(1, 0, 1, 16'h0007));
    @(negedge clk);
    check("a_rd_stat", bw(bus_a.chipselect, bus_a.write_n,
          bus_a.address, bus_a.writedata), bw(1, 1, 0, 16'h0000));
    @(negedge clk);
    check("a_rd_wait", {bus_a.chipselect, run_a}, 0);
    @(negedge clk);
    check("a_running", run_a, 1);

    // tick rate with the timer model
    en_b = 1'b1;
    wait_run(20);
    wait_pulse(120, w);
    s1 = int'(s_b);
    k1 = n_clr;
    wait_pulse(60, w);
    check("sec_intv", (w >= 39 && w <= 41) ? 40 : w, 40);
    check("sec_inc", s_b, s1 + 1);
    check("clr_per_sec", n_clr - k1, 4);

    // 23:59:59 rolls to 00:00:00 with one pulse
    sh_b = 5'd23; sm_b = 6'd59; ss_b = 6'd59; sv_b = 1'b1;
    cnt = 0;
    first = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 1) begin
        sv_b = 1'b0;
        check("pulse_width", p_b, 0);
      end
      if (k == 20) check("set_hold", tod(h_b, m_b, s_b), tod(23, 59, 59));
      if (p_b) begin
        cnt++;
        if (first == 0) first = k;
      end
    end
    check("roll_pulses", cnt, 1);
    check("roll_delay", (first >= 39 && first <= 41) ? 40 : first, 40);
    check("roll_tod", tod(h_b, m_b, s_b), 0);

    // clamping of out-of-range set values
    sh_b = 5'd31; sm_b = 6'd63; ss_b = 6'd63; sv_b = 1'b1;
    @(negedge clk);
    sv_b = 1'b0;
    check("clamp", tod(h_b, m_b, s_b), tod(23, 59, 59));

    // set_valid on the wrapping tick wins, no pulse
    wait_clr(4, 60);
    sh_b = 5'd12; sm_b = 6'd34; ss_b = 6'd56; sv_b = 1'b1;
    @(negedge clk);
    sv_b = 1'b0;
    check("coinc_pulse", p_b, 0);
    check("coinc_tod", tod(h_b, m_b, s_b), tod(12, 34, 56));
    repeat (5) @(negedge clk);
    check("coinc_hold", tod(h_b, m_b, s_b), tod(12, 34, 56));

    // enable drop while irq pending in WAIT_IRQ
    w = 0;
    while (!(bus_b.irq && !(bus_b.chipselect && !bus_b.write_n)) && w < 30) begin
      @(negedge clk);
      w++;
    end
    if (!bus_b.irq) check("irq_timeout", bus_b.irq, 1);
    en_b = 1'b0;
    snap_s = int'(s_b);
    snap_c = n_clr;
    @(negedge clk);
    check("stop_wr", bw(bus_b.chipselect, bus_b.write_n,
          bus_b.address, bus_b.writedata), bw(1, 0, 1, 16'h0008));
    @(negedge clk);
    check("stop_idle", {bus_b.chipselect, run_b}, 0);
    repeat (5) @(negedge clk);
    check("stop_noclr", n_clr, snap_c);
    check("stop_notick", s_b, snap_s);

    // start verification failing every time
    norun = 1'b1;
    snap_c = n_start;
    en_b = 1'b1;
    repeat (30) @(negedge clk);
    check("retry_cnt", n_start - snap_c, 3);
    check("err_set", err_b, 1);
    check("err_norun", run_b, 0);
    snap_c = n_cs;
    repeat (10) @(negedge clk);
    check("err_quiet", n_cs, snap_c);
    en_b = 1'b0;
    @(negedge clk);
    check("err_clear", err_b, 0);

    // asynchronous reset in the middle of a status clear
    norun = 1'b0;
    en_b = 1'b1;
    wait_run(20);
    wait_clr(1, 40);
    check("pre_rst_wn", bus_b.write_n, 0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_bus", bw(bus_b.chipselect, bus_b.write_n,
          bus_b.address, bus_b.writedata), bw(0, 1, 0, 0));
    check("arst_tod", tod(h_b, m_b, s_b), 0);
    check("arst_flags", {p_b, run_b, err_b}, 0);
    check("arst_a", {bus_a.chipselect, bus_a.write_n, run_a}, 3'b010);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
